mux_scan_n: RTL and testbench
=============================

# mux_scan_n

Parametrised, registered N-channel multiplexer with manual and auto-scan modes. It generalises the lab's combinational 4:1 mux to CH channels of W bits. It adds a dwell-timed round-robin scanner that steps through the channels enabled by a mask, plus hold, wrap and valid indications. The block sits between parallel sources (switches, counters, sensor lines) and a single shared downstream consumer such as a 7-segment driver or LED bank.

## Interface
- CH, 4, number of input channels (≥2)
- W, 1, bit width of each channel
- DWELL, 4, clock cycles each channel is presented in auto-scan (≥1)
- SELW (localparam), $clog2(CH), width of select/channel index

- clk  input  1  rising-edge clock; the block's one clock
- rst  input  1  asynchronous, active-high reset
- din  input  CH*W  packed channels; channel k at din[k*W +: W]
- mode  input  1  0 = manual select, 1 = auto-scan
- sel  input  SELW  manual channel index
- en_mask  input  CH  bit k = 1 enables channel k for auto-scan
- hold  input  1  freeze the scan position and dwell counter (auto-scan only)
- dout  output  W  registered selected data
- ch  output  SELW  index of the channel currently on dout
- valid  output  1  dout carries real channel data
- wrap  output  1  one-cycle pulse when the scan returns to a lower-or-equal index

## Operation
- All outputs are registered and update on the rising clk edge from inputs sampled at that edge.
- Reset (async, any time, including mid-scan) forces dout=0, ch=0, valid=0, wrap=0, dwell counter=0 and state=MANUAL.
- FSM states:
  - MANUAL: entered from any state when mode=0 is sampled. Each edge sets cur←sel.
    - If sel<CH: dout←din[sel], valid←1.
    - If sel≥CH (non-power-of-2 CH): dout←0, valid←0, ch←sel.
    - wrap is always 0.
  - SCAN: entered when mode=1 is sampled and en_mask≠0.
    - On entry: cur←lowest enabled index, dwell←0, valid←1, wrap←0.
    - Every edge: dout←din[cur] (live data, also during hold).
    - With hold=0, dwell increments. At dwell==DWELL-1, cur←next enabled index searching upward circularly from cur+1, and dwell←0.
    - wrap←1 for exactly one cycle if the new index ≤ the old index. With a single enabled channel, wrap therefore pulses at every dwell expiry.
    - With hold=1, dwell and cur are frozen and wrap←0.
    - If en_mask[cur] is 0 at an edge, cur advances immediately to the next enabled index with dwell←0. This happens even when hold=1, and wrap follows the same rule.
  - EMPTY: entered when mode=1 and en_mask==0. Sets dout←0, valid←0, wrap←0; ch holds its last value.
    - Leaves for SCAN (entry rules above) at the first edge where en_mask≠0.
- Transition SCAN→MANUAL: at the first edge with mode=0, ch←sel and dwell←0.
- Transition MANUAL→SCAN: always restarts at the lowest enabled channel; scan position is not remembered.
- Width rules: the dwell counter is $clog2(DWELL+1) bits. Index arithmetic wraps modulo CH, never modulo 2^SELW.

## Timing
- Latency from din/sel to dout/ch is 1 cycle. There is no combinational path from any input to any output.
- In SCAN with hold=0 and a static mask, each enabled channel appears on ch for exactly DWELL consecutive cycles.
- A mode change takes effect on the first edge at which it is sampled.
- A mask change takes effect on the next edge.
- wrap is high only in the first cycle of the new channel's dwell.

## Test plan
- CH=4, W=1, din={1,0,1,0} (in3..in0), mode=0, sel stepped 0,1,2,3 every 2 cycles -> dout 0,1,0,1 one cycle after each sel change; ch tracks sel; valid=1; wrap=0.
- Same din, DWELL=2, en_mask=4'b1111, mode=1 -> ch sequence 0,0,1,1,2,2,3,3,0,0; wrap=1 only in the first cycle back at ch=0; dout follows 0,0,1,1,0,0,1,1.
- en_mask=4'b1010, DWELL=2, mode=1 -> ch 1,1,3,3,1,1 with wrap on each return to 1. Then clear en_mask[3] while ch=3 -> next cycle ch=1, dwell restarts, wrap=1.
- Scanning at ch=2: assert hold for 5 cycles while toggling din[2] -> ch stays 2, dout follows din[2], wrap=0. On hold release, ch=2 completes its remaining dwell, then moves to 3.
- en_mask=0 with mode=1 -> valid=0, dout=0. Set en_mask=4'b0100 -> next edge ch=2, valid=1; wrap pulses every DWELL cycles.
- Assert rst asynchronously mid-dwell at ch=3 -> outputs go to 0 immediately, without waiting for clk. After release with mode=1, the scan restarts at the lowest enabled channel with a full dwell.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered CH-channel multiplexer with manual select and dwell-timed
// round-robin auto-scan over a channel enable mask.
module mux_scan_n #(
    parameter  int CH    = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SELW  = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] din,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [CH-1:0]   en_mask,
    input  logic            hold,
    output logic [W-1:0]    dout,
    output logic [SELW-1:0] ch,
    output logic            valid,
    output logic            wrap
);

    localparam int DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);
    localparam logic [SELW:0] CH_V = CH[SELW:0];

    typedef enum logic [1:0] {
        S_MANUAL,
        S_SCAN,
        S_EMPTY
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_dwell;
    logic [W-1:0]    r_dout;
    logic [SELW-1:0] r_ch;
    logic            r_valid;
    logic            r_wrap;

    logic [SELW-1:0] w_lowest;
    logic [SELW-1:0] w_hi;
    logic            w_hi_f;
    logic [SELW-1:0] w_next;
    logic            w_cur_ok;
    logic            w_sel_ok;
    logic [W-1:0]    w_sel_data;
    logic            w_adv;
    logic [SELW-1:0] w_scan_ch;
    logic [W-1:0]    w_scan_data;

    // Next enabled index above cur, else wrap to the lowest enabled one.
    always_comb begin
        w_lowest   = '0;
        w_hi       = '0;
        w_hi_f     = 1'b0;
        w_cur_ok   = 1'b0;
        w_sel_data = '0;
        for (int j = CH - 1; j >= 0; j--) begin
            if (en_mask[j]) begin
                w_lowest = SELW'(j);
                if (j > int'(r_ch)) begin
                    w_hi   = SELW'(j);
                    w_hi_f = 1'b1;
                end
            end
            if (r_ch == SELW'(j)) w_cur_ok = en_mask[j];
            if (sel == SELW'(j)) w_sel_data = din[j*W +: W];
        end
        w_next   = w_hi_f ? w_hi : w_lowest;
        w_sel_ok = ({1'b0, sel} < CH_V);
    end

    always_comb begin
        w_adv       = 1'b0;
        w_scan_ch   = r_ch;
        w_scan_data = '0;
        if (r_state != S_SCAN) begin
            w_scan_ch = w_lowest;
        end else if (!w_cur_ok || (!hold && r_dwell == DW_LAST)) begin
            w_adv     = 1'b1;
            w_scan_ch = w_next;
        end
        for (int k = 0; k < CH; k++) begin
            if (w_scan_ch == SELW'(k)) w_scan_data = din[k*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_MANUAL;
            r_dwell <= '0;
            r_dout  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!mode) begin
            r_state <= S_MANUAL;
            r_dwell <= '0;
            r_ch    <= sel;
            r_dout  <= w_sel_ok ? w_sel_data : '0;
            r_valid <= w_sel_ok;
            r_wrap  <= 1'b0;
        end else if (en_mask == '0) begin
            r_state <= S_EMPTY;
            r_dwell <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= S_SCAN;
            r_ch    <= w_scan_ch;
            r_dout  <= w_scan_data;
            r_valid <= 1'b1;
            r_wrap  <= w_adv && (w_scan_ch <= r_ch);
            if (r_state != S_SCAN || w_adv) begin
                r_dwell <= '0;
            end else if (!hold) begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    assign dout  = r_dout;
    assign ch    = r_ch;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: CH=4, W=1, DWELL=2.
module tb_mux_scan_n;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] en_mask;
    logic       hold;
    logic [0:0] dout;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;

    int n_pass = 0;
    int n_total = 0;

    mux_scan_n #(.CH(4), .W(1), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .sel(sel),
        .en_mask(en_mask), .hold(hold), .dout(dout), .ch(ch),
        .valid(valid), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] mask;
        logic       hold;
        logic [3:0] din;
        logic       e_dout;
        logic [1:0] e_ch;
        logic       e_valid;
        logic       e_wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, int idx, int got, int exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s[%0d] got=%0d want=%0d", nm, idx, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_out(string nm, int idx, logic ed, logic [1:0] ec,
                           logic ev, logic ew);
        chk({nm, ".dout"}, idx, int'(dout), int'(ed));
        chk({nm, ".ch"}, idx, int'(ch), int'(ec));
        chk({nm, ".valid"}, idx, int'(valid), int'(ev));
        chk({nm, ".wrap"}, idx, int'(wrap), int'(ew));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic m, logic [1:0] s, logic [3:0] k, logic h,
                       logic [3:0] d, logic ed, logic [1:0] ec,
                       logic ev, logic ew);
        tbl.push_back('{m, s, k, h, d, ed, ec, ev, ew});
    endtask

    initial begin
        // din in3..in0 = 1,0,1,0
        add(0, 0, 4'h0, 0, 4'b1010, 0, 0, 1, 0);
        add(0, 0, 4'h0, 0, 4'b1010, 0, 0, 1, 0);
        add(0, 1, 4'h0, 0, 4'b1010, 1, 1, 1, 0);
        add(0, 1, 4'h0, 0, 4'b1010, 1, 1, 1, 0);
        add(0, 2, 4'h0, 0, 4'b1010, 0, 2, 1, 0);
        add(0, 2, 4'h0, 0, 4'b1010, 0, 2, 1, 0);
        add(0, 3, 4'h0, 0, 4'b1010, 1, 3, 1, 0);
        add(0, 3, 4'h0, 0, 4'b1010, 1, 3, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 0, 0, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 0, 0, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 0, 2, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 0, 2, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 1, 3, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 1, 3, 1, 0);
        add(1, 0, 4'hf, 0, 4'b1010, 0, 0, 1, 1);
        add(1, 0, 4'hf, 0, 4'b1010, 0, 0, 1, 0);
        add(0, 1, 4'hf, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 3, 1, 0);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 3, 1, 0);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 1, 1, 1);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'ha, 0, 4'b1010, 1, 3, 1, 0);
        add(1, 0, 4'h2, 0, 4'b1010, 1, 1, 1, 1);
        add(1, 0, 4'h2, 0, 4'b1010, 1, 1, 1, 0);
        add(1, 0, 4'h2, 0, 4'b1010, 1, 1, 1, 1);
        add(1, 0, 4'h0, 0, 4'b1010, 0, 1, 0, 0);
        add(1, 0, 4'h0, 0, 4'b1010, 0, 1, 0, 0);
        add(1, 0, 4'h4, 0, 4'b1110, 1, 2, 1, 0);
        add(1, 0, 4'h4, 0, 4'b1110, 1, 2, 1, 0);
        add(1, 0, 4'h4, 0, 4'b1110, 1, 2, 1, 1);
        add(1, 0, 4'h4, 0, 4'b1110, 1, 2, 1, 0);
        add(1, 0, 4'h4, 0, 4'b1110, 1, 2, 1, 1);

        rst = 1'b1;
        din = 4'b1010;
        mode = 1'b0;
        sel = 2'd0;
        en_mask = 4'h0;
        hold = 1'b0;
        #12;
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            sel = tbl[i].sel;
            en_mask = tbl[i].mask;
            hold = tbl[i].hold;
            din = tbl[i].din;
            step();
            chk_out("vec", i, tbl[i].e_dout, tbl[i].e_ch,
                    tbl[i].e_valid, tbl[i].e_wrap);
        end

        // Hold at ch=2 while din[2] toggles, then finish the dwell.
        mode = 1'b0;
        sel = 2'd0;
        din = 4'b1010;
        hold = 1'b0;
        step();
        mode = 1'b1;
        en_mask = 4'hf;
        for (int i = 0; i < 5; i++) step();
        chk_out("hold_pre", 0, 0, 2, 1, 0);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din[2] = ~din[2];
            step();
            chk_out("hold", i, din[2], 2, 1, 0);
        end
        hold = 1'b0;
        din = 4'b1010;
        step();
        chk_out("hold_rel", 0, 0, 2, 1, 0);
        step();
        chk_out("hold_rel", 1, 1, 3, 1, 0);

        // Asynchronous reset mid-dwell at ch=3.
        #3;
        rst = 1'b1;
        #1;
        chk_out("arst", 0, 0, 0, 0, 0);
        en_mask = 4'ha;
        #2;
        rst = 1'b0;
        step();
        chk_out("arst_rs", 0, 1, 1, 1, 0);
        step();
        chk_out("arst_rs", 1, 1, 1, 1, 0);
        step();
        chk_out("arst_rs", 2, 1, 3, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
